// File: rtl/stochastic_mult_seq_if.sv
// Host-side bundle for the sequential stochastic multiplier.
// The master drives the request; the slave returns status, result and raw stream bits.
interface stochastic_mult_seq_if #(parameter int W = 14);
  logic         start;
  logic [W-1:0] a_val;
  logic [W-1:0] b_val;
  logic [1:0]   mode;
  logic         busy;
  logic         done;
  logic [W:0]   result;
  logic         a_bit;
  logic         b_bit;
  logic         y_bit;
  logic         bit_valid;

  modport master (
    output start, a_val, b_val, mode,
    input  busy, done, result, a_bit, b_bit, y_bit, bit_valid
  );

  modport slave (
    input  start, a_val, b_val, mode,
    output busy, done, result, a_bit, b_bit, y_bit, bit_valid
  );
endinterface

// File: rtl/stochastic_mult_seq.sv
// Sequential stochastic multiplier: counter-comparator A stream, bit-reversed-counter
// B stream, combined over one 2^W-cycle period and popcounted into result.
module stochastic_mult_seq #(
  parameter int W = 14
) (
  input  logic                 clk,
  input  logic                 rst,
  stochastic_mult_seq_if.slave bus
);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  state_e       state_q, state_d;
  logic [W-1:0] c_q, c_d;
  logic [W:0]   acc_q, acc_d;
  logic [W:0]   result_q, result_d;
  logic         done_q, done_d;
  logic [W-1:0] a_lat_q, a_lat_d;
  logic [W-1:0] b_lat_q, b_lat_d;
  logic [1:0]   mode_q, mode_d;

  logic         a_bit_s;
  logic         b_bit_s;
  logic         y_bit_s;

  function automatic logic [W-1:0] bitrev(input logic [W-1:0] v);
    logic [W-1:0] r;
    for (int i = 0; i < W; i++) begin
      r[i] = v[W-1-i];
    end
    return r;
  endfunction

  // Stream bits derive from the registered counter and latched operands only.
  always_comb begin
    a_bit_s = (c_q < a_lat_q);
    b_bit_s = (bitrev(c_q) < b_lat_q);
    case (mode_q)
      2'd0:    y_bit_s = a_bit_s & b_bit_s;
      2'd1:    y_bit_s = ~(a_bit_s ^ b_bit_s);
      2'd2:    y_bit_s = a_bit_s;
      2'd3:    y_bit_s = b_bit_s;
      default: y_bit_s = 1'b0;
    endcase
  end

  // Next-state, accumulation and completion logic.
  always_comb begin
    state_d  = state_q;
    c_d      = c_q;
    acc_d    = acc_q;
    result_d = result_q;
    done_d   = 1'b0;
    a_lat_d  = a_lat_q;
    b_lat_d  = b_lat_q;
    mode_d   = mode_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          a_lat_d = bus.a_val;
          b_lat_d = bus.b_val;
          mode_d  = bus.mode;
          c_d     = {W{1'b0}};
          acc_d   = {(W+1){1'b0}};
          state_d = ST_RUN;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        acc_d = acc_q + {{W{1'b0}}, y_bit_s};
        c_d   = c_q + {{(W-1){1'b0}}, 1'b1};
        // Last index of the period: the final bit goes straight into result.
        if (c_q == {W{1'b1}}) begin
          result_d = acc_q + {{W{1'b0}}, y_bit_s};
          done_d   = 1'b1;
          state_d  = ST_IDLE;
        end else begin
          state_d  = ST_RUN;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State register with synchronous reset; reset aborts a run and clears result.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      c_q      <= {W{1'b0}};
      acc_q    <= {(W+1){1'b0}};
      result_q <= {(W+1){1'b0}};
      done_q   <= 1'b0;
      a_lat_q  <= {W{1'b0}};
      b_lat_q  <= {W{1'b0}};
      mode_q   <= 2'd0;
    end else begin
      state_q  <= state_d;
      c_q      <= c_d;
      acc_q    <= acc_d;
      result_q <= result_d;
      done_q   <= done_d;
      a_lat_q  <= a_lat_d;
      b_lat_q  <= b_lat_d;
      mode_q   <= mode_d;
    end
  end

  assign bus.busy      = (state_q == ST_RUN);
  assign bus.bit_valid = (state_q == ST_RUN);
  assign bus.done      = done_q;
  assign bus.result    = result_q;
  assign bus.a_bit     = a_bit_s;
  assign bus.b_bit     = b_bit_s;
  assign bus.y_bit     = y_bit_s;

endmodule

// File: tb/tb_stochastic_mult_seq.sv
// Scoreboard bench: expected popcounts queued at start, compared when done pulses.
module tb_stochastic_mult_seq;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  stochastic_mult_seq_if #(.W(4))  dif   ();
  stochastic_mult_seq_if #(.W(14)) dif14 ();

  stochastic_mult_seq #(.W(4)) dut4 (
    .clk (clk),
    .rst (rst),
    .bus (dif)
  );

  stochastic_mult_seq #(.W(14)) dut14 (
    .clk (clk),
    .rst (rst),
    .bus (dif14)
  );

  int n_checks = 0;
  int n_err    = 0;
  int sb_q[$];
  int cyc      = 0;
  int done_at  = 0;
  int busy_cnt = 0;
  int ysum     = 0;
  int held     = 0;
  logic prev_done = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int model(input int a, input int b, input int m);
    int s = 0;
    for (int c = 0; c < 16; c++) begin
      logic [3:0] cv;
      logic [3:0] rv;
      logic ab, bb, y;
      cv = c[3:0];
      rv = {cv[0], cv[1], cv[2], cv[3]};
      ab = (c < a);
      bb = (int'(rv) < b);
      case (m)
        0:       y = ab & bb;
        1:       y = ~(ab ^ bb);
        2:       y = ab;
        default: y = bb;
      endcase
      s += int'(y);
    end
    return s;
  endfunction

  // Monitor for the W=4 instance: scoreboard pop, pulse shape, result stability
  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      busy_cnt  = 0;
      ysum      = 0;
      held      = 0;
      prev_done = 1'b0;
    end else begin
      check_eq("bit_valid", 32'(dif.bit_valid), 32'(dif.busy));
      check_eq("done_pulse", 32'(dif.done & prev_done), 32'd0);
      if (dif.done) begin
        if (sb_q.size() == 0) begin
          check_eq("spurious_done", 32'(dif.done), 32'd0);
        end else begin
          int exp_v;
          exp_v = sb_q.pop_front();
          check_eq("result", 32'(dif.result), exp_v);
          check_eq("busy_len", busy_cnt, 32'd16);
          check_eq("y_popcount", 32'(dif.result), ysum);
        end
        held     = int'(dif.result);
        done_at  = cyc;
        busy_cnt = 0;
        ysum     = 0;
      end else begin
        check_eq("result_hold", 32'(dif.result), held);
      end
      if (dif.busy) begin
        busy_cnt++;
        ysum += int'(dif.y_bit);
      end
      prev_done = dif.done;
    end
  end

  task automatic start_run(input int a, input int b, input int m);
    for (int i = 0; i < 40 && dif.busy; i++) begin
      @(posedge clk); #1;
    end
    check_eq("idle_wait", 32'(dif.busy), 32'd0);
    dif.a_val = a[3:0];
    dif.b_val = b[3:0];
    dif.mode  = m[1:0];
    dif.start = 1'b1;
    @(posedge clk); #1;
    dif.start = 1'b0;
  endtask

  task automatic wait_q(input int target, input int max_cyc);
    for (int i = 0; i < max_cyc && sb_q.size() != target; i++) begin
      @(posedge clk); #1;
    end
    check_eq("sb_wait", sb_q.size(), target);
  endtask

  task automatic run_one(input int a, input int b, input int m, input int exp_v);
    sb_q.push_back(exp_v);
    start_run(a, b, m);
    wait_q(0, 40);
  endtask

  initial begin
    int t1, t2, t3, cnt14;
    dif.start = 1'b0; dif.a_val = 4'd0; dif.b_val = 4'd0; dif.mode = 2'd0;
    dif14.start = 1'b0; dif14.a_val = 14'd0; dif14.b_val = 14'd0; dif14.mode = 2'd0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_busy", 32'(dif.busy), 32'd0);
    check_eq("rst_done", 32'(dif.done), 32'd0);
    check_eq("rst_bv", 32'(dif.bit_valid), 32'd0);
    check_eq("rst_result", 32'(dif.result), 32'd0);
    check_eq("rst_result14", 32'(dif14.result), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Directed points with hand-derived answers
    run_one(8, 8, 0, 4);
    run_one(8, 8, 1, 8);
    run_one(15, 15, 0, 15);
    run_one(0, 15, 0, 0);

    // Full sweep: SNG self-check modes plus golden-model multiply modes
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        run_one(a, b, 2, a);
        run_one(a, b, 3, b);
        run_one(a, b, 0, model(a, b, 0));
        run_one(a, b, 1, model(a, b, 1));
      end
    end

    // Start held high: back-to-back runs, operands changed mid-run
    sb_q.push_back(model(3, 5, 0));
    dif.a_val = 4'd3; dif.b_val = 4'd5; dif.mode = 2'd0;
    dif.start = 1'b1;
    @(posedge clk); #1;
    repeat (5) @(posedge clk);
    #1;
    dif.a_val = 4'd10; dif.b_val = 4'd12;
    sb_q.push_back(model(10, 12, 0));
    wait_q(1, 40);
    t1 = done_at;
    sb_q.push_back(model(10, 12, 0));
    wait_q(1, 40);
    t2 = done_at;
    check_eq("period_a", t2 - t1, 32'd17);
    dif.start = 1'b0;
    wait_q(0, 40);
    t3 = done_at;
    check_eq("period_b", t3 - t2, 32'd17);
    repeat (25) @(posedge clk);
    #1;

    // Abort a run with reset at its 7th cycle
    start_run(9, 9, 0);
    repeat (6) @(posedge clk);
    #1;
    check_eq("pre_abort_busy", 32'(dif.busy), 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check_eq("abort_busy", 32'(dif.busy), 32'd0);
    check_eq("abort_done", 32'(dif.done), 32'd0);
    check_eq("abort_result", 32'(dif.result), 32'd0);
    repeat (30) @(posedge clk);
    #1;
    run_one(5, 6, 0, model(5, 6, 0));

    // Full-width instance: 8192/16384 * 4096/16384 over 16384 cycles
    dif14.a_val = 14'd8192; dif14.b_val = 14'd4096; dif14.mode = 2'd0;
    dif14.start = 1'b1;
    @(posedge clk); #1;
    dif14.start = 1'b0;
    cnt14 = 0;
    for (int i = 0; i < 17000; i++) begin
      @(negedge clk);
      if (dif14.busy) cnt14++;
      if (dif14.done) break;
    end
    check_eq("w14_done", 32'(dif14.done), 32'd1);
    check_eq("w14_busy_len", cnt14, 32'd16384);
    check_eq("w14_result", 32'(dif14.result), (32'd8192 * 32'd4096) >> 14);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/stochastic_mult_seq.md
# stochastic_mult_seq

Sequential, parametrised successor to the combinational stochastic multiplier. It accepts two W-bit binary probabilities and generates its own low-discrepancy bitstreams: a counter-comparator stream for A and a bit-reversed-counter stream for B. It combines the streams bit-serially over one full 2^W-cycle period in a selectable mode and returns the popcount of the result stream with a start/done handshake. It sits between binary-domain control logic and stochastic datapaths, and also exposes the raw per-cycle bits for downstream stochastic consumers.

## Interface
- W, 14: operand width; stream length L = 2^W cycles (W=14 gives 16384).
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request a run; honoured only when busy=0.
- a_val  in  W  operand A; p_a = a_val / 2^W.
- b_val  in  W  operand B; p_b = b_val / 2^W.
- mode  in  2  0: unipolar multiply (AND), 1: bipolar multiply (XNOR), 2: A stream only, 3: B stream only.
- busy  out  1  run in progress.
- done  out  1  one-cycle pulse: result valid and updated.
- result  out  W+1  ones count of the Y stream from the last completed run (0..2^W).
- a_bit, b_bit, y_bit  out  1 each  current stream bits; meaningful only while bit_valid=1.
- bit_valid  out  1  equals busy.

## Operation
- State is IDLE (busy=0) or RUN (busy=1). There is no other state.
- IDLE to RUN: at an edge with start=1 and busy=0, latch a_val, b_val and mode; clear the W-bit cycle counter c and the W+1-bit accumulator acc; set busy=1.
- Streams are combinational from the registered c and the latched operands:
  - a_bit = (c < a_lat)
  - b_bit = (bitrev_W(c) < b_lat)
  - y_bit is a_bit & b_bit (mode 0), ~(a_bit ^ b_bit) (mode 1), a_bit (mode 2) or b_bit (mode 3).
- Each RUN edge: acc <= acc + y_bit and c <= c + 1.
- RUN to IDLE: at the RUN edge where c = 2^W-1, result <= acc + y_bit, done <= 1, busy <= 0, and c wraps to 0.
- Over a full period the A stream contains exactly a_val ones and the B stream exactly b_val ones. Modes 2 and 3 therefore return a_val and b_val exactly and serve as SNG self-check.
- For mode 1, the host interprets the result as bipolar: 2*result/2^W - 1.
- start while busy=1 is ignored. Input changes during RUN have no effect, because operands are latched.
- result holds its value from one done to the next. It never changes mid-run.
- Width rule: acc and result are W+1 bits, so that a count of 2^W cannot overflow.

## Timing
- Reset values: busy=0, done=0, bit_valid=0, result=0, c=0, acc=0. a_bit, b_bit and y_bit are don't-care while bit_valid=0.
- rst=1 mid-run aborts the run. done is not pulsed and result is forced to 0.
- Start accepted at edge E0. busy is high for exactly 2^W cycles, from after E0 until edge E0+2^W. done is high for the one cycle after edge E0+2^W.
- Start-to-done latency is 2^W cycles. The stream bit for index k is visible in the cycle after edge E0+k.
- Back-to-back runs: start is accepted in the cycle where done=1, because busy=0 then. The next run begins at the following edge, giving a throughput of one run per 2^W+1 cycles.
- done is cleared at every edge where it is not being set. It never stays high for two consecutive cycles.

## Test plan
- W=4, mode 0, a=8, b=8: busy for 16 cycles, then done; result = 4 (0.25). bit_valid is high for exactly 16 cycles.
- W=4, mode 1, a=8, b=8: result = 8 (bipolar 0.0). Repeat with a=15, b=15 in mode 0: result = 15. Repeat with a=0, b=15 in mode 0: result = 0.
- W=4, modes 2 and 3 over all a, b in 0..15: result equals a and b respectively. Mode 0 result matches the golden model sum over c of (c<a)&(rev(c)<b).
- Handshake: hold start=1 continuously. Runs repeat every 17 cycles with one-cycle done pulses. Operands changed mid-run do not affect the running result. result is stable between pulses.
- Reset: assert rst at cycle 7 of a run. Next cycle: busy=0, done=0, result=0. No done is pulsed afterwards until a new start.
- W=14 default, mode 0, a=8192, b=4096: result = 2048 after 16384 busy cycles. Absolute error versus p_a*p_b is 0.
